// File: rtl/systolic_ctrl.sv
// Sequencing controller for an N x N systolic array: loads N weight rows,
// streams num_vec input vectors, waits for the array to drain, then pulses done.
module systolic_ctrl #(
    parameter int N         = 4,
    parameter int DRAIN_CYC = 2 * N - 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [7:0]           num_vec,
    input  logic                 float_in,
    input  logic                 weight_valid,
    output logic                 weight_ready,
    output logic                 load,
    output logic [$clog2(N)-1:0] load_row,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 feed_valid,
    output logic                 float_mode,
    input  logic                 ovf_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int RW = $clog2(N);
    localparam int DW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [RW-1:0]   row_cnt;
    logic [7:0]      vec_cnt;
    logic [7:0]      nv_q;
    logic [DW-1:0]   drain_cnt;

    logic            last_row;
    logic            last_vec;
    logic            last_drain;

    assign last_row   = (row_cnt == RW'(N - 1));
    // Widened compare so num_vec=255 terminates without the counter wrapping first.
    assign last_vec   = (({1'b0, vec_cnt} + 9'd1) == {1'b0, nv_q});
    assign last_drain = (drain_cnt == DW'(DRAIN_CYC - 1));

    // Handshake outputs decode the state register directly so reset clears them at once.
    assign weight_ready = (state == LOAD_W);
    assign in_ready     = (state == STREAM);
    assign load         = weight_valid & weight_ready;
    assign feed_valid   = in_valid & in_ready;
    assign load_row     = row_cnt;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    // NOTE: every register here is updated with <= so all flops see pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            row_cnt    <= '0;
            vec_cnt    <= '0;
            nv_q       <= '0;
            drain_cnt  <= '0;
            float_mode <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD_W;
                        nv_q       <= num_vec;
                        float_mode <= float_in;
                        err        <= 1'b0;
                        row_cnt    <= '0;
                        vec_cnt    <= '0;
                        drain_cnt  <= '0;
                    end
                end
                LOAD_W: begin
                    if (weight_valid) begin
                        if (last_row) begin
                            row_cnt <= '0;
                            state   <= (nv_q != 8'd0) ? STREAM : DONE;
                        end else begin
                            row_cnt <= row_cnt + RW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (ovf_in) begin
                        err <= 1'b1;
                    end
                    if (in_valid) begin
                        vec_cnt <= vec_cnt + 8'd1;
                        if (last_vec) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (ovf_in) begin
                        err <= 1'b1;
                    end
                    if (last_drain) begin
                        drain_cnt <= '0;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomised and directed bench for systolic_ctrl; expected waveforms come from
// a per-job timeline built by scanning the pre-generated valid patterns.
module tb_systolic_ctrl;

    localparam int N         = 4;
    localparam int DRAIN_CYC = 2 * N - 1;
    localparam int MAXC      = 700;

    logic                 clk;
    logic                 n_rst;
    logic                 start;
    logic [7:0]           num_vec;
    logic                 float_in;
    logic                 weight_valid;
    logic                 weight_ready;
    logic                 load;
    logic [$clog2(N)-1:0] load_row;
    logic                 in_valid;
    logic                 in_ready;
    logic                 feed_valid;
    logic                 float_mode;
    logic                 ovf_in;
    logic                 busy;
    logic                 done;
    logic                 err;

    int tests = 0;
    int fails = 0;

    bit wv_a   [MAXC];
    bit iv_a   [MAXC];
    bit ovf_a  [MAXC];
    bit e_wr   [MAXC];
    bit e_load [MAXC];
    bit e_inr  [MAXC];
    bit e_feed [MAXC];
    int e_row  [MAXC];

    systolic_ctrl #(.N(N), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .num_vec      (num_vec),
        .float_in     (float_in),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready),
        .load         (load),
        .load_row     (load_row),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .feed_valid   (feed_valid),
        .float_mode   (float_mode),
        .ovf_in       (ovf_in),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_weight_ready"}, 0, 32'(weight_ready), 0);
        check({tag, "_load"},         0, 32'(load),         0);
        check({tag, "_load_row"},     0, 32'(load_row),     0);
        check({tag, "_in_ready"},     0, 32'(in_ready),     0);
        check({tag, "_feed_valid"},   0, 32'(feed_valid),   0);
        check({tag, "_float_mode"},   0, 32'(float_mode),   0);
        check({tag, "_busy"},         0, 32'(busy),         0);
        check({tag, "_done"},         0, 32'(done),         0);
        check({tag, "_err"},          0, 32'(err),          0);
    endtask

    // wv_mode/iv_mode: 0 always valid, 1 weight stall in cycles 2-3, 2 random.
    // ovf_mode: 0 none, 1 random on any cycle, 2 single pulse inside DRAIN.
    // Must be entered mid-cycle while the DUT is in IDLE; returns mid-cycle in IDLE.
    task automatic run_job(input int nv, input bit fl, input int wv_mode, input int iv_mode,
                           input int ovf_mode, input bit hold);
        int  c;
        int  rows;
        int  cnt;
        int  s_first;
        int  done_c;
        int  pulse_c;
        bit  err_acc;

        for (int k = 0; k < MAXC; k++) begin
            wv_a[k]   = (wv_mode == 0) ? 1'b1 :
                        (wv_mode == 1) ? !(k == 2 || k == 3) :
                        (k > 300 || $urandom_range(99) < 60);
            iv_a[k]   = (iv_mode == 0) ? 1'b1 : (k > 300 || $urandom_range(99) < 60);
            ovf_a[k]  = 1'b0;
            e_wr[k]   = 1'b0;
            e_load[k] = 1'b0;
            e_inr[k]  = 1'b0;
            e_feed[k] = 1'b0;
            e_row[k]  = 0;
        end

        // Timeline: N accepted rows, then nv accepted vectors, then DRAIN_CYC, then done.
        c    = 1;
        rows = 0;
        while (rows < N) begin
            e_wr[c]  = 1'b1;
            e_row[c] = rows;
            if (wv_a[c]) begin
                e_load[c] = 1'b1;
                rows++;
            end
            c++;
        end
        s_first = c;
        cnt     = 0;
        while (cnt < nv) begin
            e_inr[c] = 1'b1;
            if (iv_a[c]) begin
                e_feed[c] = 1'b1;
                cnt++;
            end
            c++;
        end
        if (nv > 0) c += DRAIN_CYC;
        done_c = c;

        if (ovf_mode == 1) begin
            for (int k = 1; k <= done_c + 1; k++) ovf_a[k] = ($urandom_range(99) < 15);
        end else if (ovf_mode == 2 && nv > 0) begin
            pulse_c        = done_c - 1 - int'($urandom_range(DRAIN_CYC - 1));
            ovf_a[pulse_c] = 1'b1;
        end

        start    = 1'b1;
        num_vec  = 8'(nv);
        float_in = fl;
        @(posedge clk);
        #1;
        err_acc = 1'b0;
        for (int cc = 1; cc <= done_c + 1; cc++) begin
            weight_valid = wv_a[cc];
            in_valid     = iv_a[cc];
            ovf_in       = ovf_a[cc];
            if (!hold) begin
                start    = (cc <= done_c) ? 1'($urandom_range(1)) : 1'b0;
                num_vec  = 8'($urandom);
                float_in = 1'($urandom_range(1));
            end
            @(negedge clk);
            check("weight_ready", cc, 32'(weight_ready), 32'(e_wr[cc]));
            check("load",         cc, 32'(load),         32'(e_load[cc]));
            if (e_wr[cc]) check("load_row", cc, 32'(load_row), 32'(e_row[cc]));
            check("in_ready",     cc, 32'(in_ready),     32'(e_inr[cc]));
            check("feed_valid",   cc, 32'(feed_valid),   32'(e_feed[cc]));
            check("load_feed_excl", cc, 32'(load & feed_valid), 0);
            if (cc != done_c) check("busy", cc, 32'(busy), 32'(cc < done_c));
            check("done",         cc, 32'(done),         32'(cc == done_c));
            check("err",          cc, 32'(err),          32'(err_acc));
            check("float_mode",   cc, 32'(float_mode),   32'(fl));
            if (cc >= s_first && cc < done_c && ovf_a[cc]) err_acc = 1'b1;
            if (cc <= done_c) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        n_rst        = 1'b0;
        start        = 1'b0;
        num_vec      = '0;
        float_in     = 1'b0;
        weight_valid = 1'b1;
        in_valid     = 1'b1;
        ovf_in       = 1'b0;

        #2;
        check_reset_outputs("por");
        @(negedge clk);
        n_rst = 1'b1;

        // Reference job: num_vec=3, float, all valids high -> done in cycle 15.
        run_job(3, 1'b1, 0, 0, 0, 1'b0);
        // Weight stall in cycles 2-3.
        run_job(3, 1'b0, 1, 0, 0, 1'b0);
        // No vectors: straight from LOAD_W to DONE.
        run_job(0, 1'b1, 0, 0, 0, 1'b0);
        // Overflow pulse inside DRAIN, then a clean job that must clear err.
        run_job(4, 1'b0, 0, 0, 2, 1'b0);
        run_job(2, 1'b1, 0, 0, 0, 1'b0);

        // Reset mid-STREAM after two of five vectors.
        start    = 1'b1;
        num_vec  = 8'd5;
        float_in = 1'b1;
        weight_valid = 1'b1;
        in_valid     = 1'b1;
        ovf_in       = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_in_ready", 7, 32'(in_ready), 1);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        @(negedge clk);
        n_rst = 1'b1;
        run_job(5, 1'b1, 0, 0, 0, 1'b0);

        // start held high: back-to-back jobs with a single IDLE cycle between.
        run_job(2, 1'b0, 0, 0, 0, 1'b1);
        run_job(2, 1'b0, 0, 0, 0, 1'b1);
        run_job(2, 1'b0, 0, 0, 0, 1'b0);

        // Random jobs: random valids, overflow noise in every phase, start noise.
        for (int j = 0; j < 20; j++) begin
            run_job(int'($urandom_range(40)), 1'($urandom_range(1)), 2, 2, 1, 1'b0);
        end
        run_job(255, 1'b1, 0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
